// File: rtl/ldpc_parity_accum.sv
// Serial quasi-cyclic LDPC parity accumulator: XORs a rotating generator row into the
// parity register for every 1 information bit, then streams the parity out MSB first.
module ldpc_parity_accum #(
    parameter int Z          = 360,
    parameter int NUM_GROUPS = 12,
    parameter int PAR_W      = 360,
    parameter int SYSTEMATIC = 1,
    parameter int AW         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din_valid,
    input  logic             din,
    output logic             din_ready,
    output logic [AW-1:0]    rom_addr,
    input  logic [PAR_W-1:0] rom_data,
    output logic             dout_valid,
    output logic             dout,
    input  logic             dout_ready,
    output logic             dout_sof,
    output logic             dout_eof,
    output logic             dout_is_parity,
    output logic             busy
);

    localparam int ZW = (Z > 1) ? $clog2(Z) : 1;
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int PW = (PAR_W > 1) ? $clog2(PAR_W) : 1;
    localparam logic [ZW-1:0] Z_LAST = ZW'(Z - 1);
    localparam logic [GW-1:0] G_LAST = GW'(NUM_GROUPS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PAR_W - 1);
    localparam logic [AW-1:0] A_LAST = AW'(NUM_GROUPS - 1);
    localparam logic [AW-1:0] A_FIRST_PREFETCH = (NUM_GROUPS > 1) ? AW'(1) : '0;
    localparam bit SYS = (SYSTEMATIC != 0);

    typedef enum logic [1:0] {IDLE, LOAD, ACCUM, PARITY} state_t;

    state_t            state;
    logic [PAR_W-1:0]  acc;
    logic [PAR_W-1:0]  row;
    logic [PAR_W-1:0]  prefetch;
    logic [ZW-1:0]     bit_cnt;
    logic [GW-1:0]     grp_cnt;
    logic [PW-1:0]     par_idx;
    logic              chg_p0;
    logic              chg_p1;
    logic              par_valid;
    logic              par_bit;
    logic              par_sof;
    logic              par_eof;
    logic              par_flag;

    logic              in_accum;
    logic              accept;
    logic              grp_end;
    logic              last_bit;
    logic [PAR_W-1:0]  acc_nxt;
    logic [PAR_W-1:0]  next_row;

    function automatic logic [PAR_W-1:0] rotr1(input logic [PAR_W-1:0] v);
        return {v[0], v[PAR_W-1:1]};
    endfunction

    // The address runs one group ahead of the row in use; once the last row has
    // been requested it parks at 0 so IDLE already presents row 0.
    function automatic logic [AW-1:0] addr_adv(input logic [AW-1:0] a);
        if (a == A_LAST || a == '0)
            return '0;
        return a + AW'(1);
    endfunction

    assign in_accum  = (state == ACCUM);
    assign din_ready = in_accum && (!SYS || dout_ready);
    assign accept    = din_valid && din_ready;
    assign grp_end   = (bit_cnt == Z_LAST);
    assign last_bit  = grp_end && (grp_cnt == G_LAST);
    assign acc_nxt   = din ? (acc ^ row) : acc;
    assign busy      = (state != IDLE);
    // A boundary that lands while the fresh ROM word is still on the bus takes it directly.
    assign next_row  = chg_p1 ? rom_data : prefetch;

    always_comb begin
        dout_valid     = par_valid;
        dout           = par_bit;
        dout_sof       = par_sof;
        dout_eof       = par_eof;
        dout_is_parity = par_flag;
        if (SYS && in_accum) begin
            dout_valid     = din_valid;
            dout           = din;
            dout_sof       = din_valid && (bit_cnt == '0) && (grp_cnt == '0);
            dout_eof       = 1'b0;
            dout_is_parity = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            row       <= '0;
            prefetch  <= '0;
            rom_addr  <= '0;
            bit_cnt   <= '0;
            grp_cnt   <= '0;
            par_idx   <= '0;
            chg_p0    <= 1'b0;
            chg_p1    <= 1'b0;
            par_valid <= 1'b0;
            par_bit   <= 1'b0;
            par_sof   <= 1'b0;
            par_eof   <= 1'b0;
            par_flag  <= 1'b0;
        end else begin
            // p0: address changed last edge; p1: synchronous ROM word for it is on rom_data
            chg_p0 <= 1'b0;
            chg_p1 <= chg_p0;
            if (chg_p1)
                prefetch <= rom_data;

            case (state)
                IDLE: begin
                    if (start)
                        state <= LOAD;
                end
                LOAD: begin
                    row      <= rom_data;
                    rom_addr <= A_FIRST_PREFETCH;
                    chg_p0   <= 1'b1;
                    bit_cnt  <= '0;
                    grp_cnt  <= '0;
                    state    <= ACCUM;
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        if (last_bit) begin
                            state     <= PARITY;
                            bit_cnt   <= '0;
                            grp_cnt   <= '0;
                            par_idx   <= P_LAST;
                            par_valid <= 1'b1;
                            par_bit   <= acc_nxt[PAR_W-1];
                            par_sof   <= !SYS;
                            par_eof   <= (PAR_W == 1);
                            par_flag  <= 1'b1;
                        end else if (grp_end) begin
                            row      <= next_row;
                            bit_cnt  <= '0;
                            grp_cnt  <= grp_cnt + GW'(1);
                            rom_addr <= addr_adv(rom_addr);
                            chg_p0   <= 1'b1;
                        end else begin
                            row     <= rotr1(row);
                            bit_cnt <= bit_cnt + ZW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (dout_ready) begin
                        if (par_idx == '0) begin
                            state     <= IDLE;
                            acc       <= '0;
                            par_valid <= 1'b0;
                            par_bit   <= 1'b0;
                            par_sof   <= 1'b0;
                            par_eof   <= 1'b0;
                            par_flag  <= 1'b0;
                        end else begin
                            par_idx <= par_idx - PW'(1);
                            par_bit <= acc[par_idx - PW'(1)];
                            par_sof <= 1'b0;
                            par_eof <= (par_idx == PW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
